// File: rtl/lab62_soc_irq_ctrl.sv
// lab62_soc_irq_ctrl: Avalon-MM interrupt aggregator for the Nios II.
// Each source is resynchronised, captured as level or edge, masked by ENABLE
// and priority-encoded. A saturating counter tracks combined-irq assertions.
module lab62_soc_irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  localparam logic [2:0] ADDR_RAW     = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_COUNT   = 3'd5;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] s_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] mode_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] edge_next;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] pend_en;
  logic               active_valid;
  logic [3:0]         active_id;
  logic               irq_out_d;
  logic               irq_rise;
  logic [15:0]        count_q;
  logic [15:0]        count_next;
  logic [15:0]        read_mux;
  logic               wr;
  logic               wr_pending;
  logic               wr_enable;
  logic               wr_mode;
  logic               wr_count;
  logic               unused_ok;

  assign wr         = chipselect & ~write_n;
  assign wr_pending = wr && (address == ADDR_PENDING);
  assign wr_enable  = wr && (address == ADDR_ENABLE);
  assign wr_mode    = wr && (address == ADDR_MODE);
  assign wr_count   = wr && (address == ADDR_COUNT);
  assign unused_ok  = &{1'b0, writedata};

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_prev;
  assign w1c_mask = wr_pending ? writedata[NUM_SRC-1:0] : '0;
  assign pend     = (mode_q & edge_q) | (~mode_q & s);
  assign pend_en  = pend & enable_q;
  assign irq_rise = irq_out & ~irq_out_d;

  // Resynchronise the raw requests and keep one cycle of history for edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_prev <= s;
    end
  end

  // Edge latch: held clear in level mode, set beats write-1-to-clear.
  always_comb begin
    edge_next = mode_q & (rise | (edge_q & ~w1c_mask));
  end

  // Control registers and edge latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= '0;
      mode_q   <= '0;
      edge_q   <= '0;
    end else begin
      if (wr_enable) enable_q <= writedata[NUM_SRC-1:0];
      if (wr_mode)   mode_q   <= writedata[NUM_SRC-1:0];
      edge_q <= edge_next;
    end
  end

  // Lowest-numbered enabled pending source wins.
  always_comb begin
    active_id    = '0;
    active_valid = |pend_en;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_en[i]) active_id = 4'(i);
    end
  end

  // Saturating event counter; a register write clears it and beats an increment.
  always_comb begin
    count_next = count_q;
    if (wr_count) count_next = '0;
    else if (irq_rise && (count_q != 16'hFFFF)) count_next = count_q + 16'd1;
  end

  // Combined interrupt, its one-cycle history and the event counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_out   <= 1'b0;
      irq_out_d <= 1'b0;
      count_q   <= '0;
    end else begin
      irq_out   <= |pend_en;
      irq_out_d <= irq_out;
      count_q   <= count_next;
    end
  end

  // Register read mux; unused addresses and bits above NUM_SRC read zero.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_RAW:     read_mux = 16'(s);
      ADDR_PENDING: read_mux = 16'(pend);
      ADDR_ENABLE:  read_mux = 16'(enable_q);
      ADDR_MODE:    read_mux = 16'(mode_q);
      ADDR_ACTIVE:  read_mux = {active_valid, 11'b0, active_id};
      ADDR_COUNT:   read_mux = count_q;
      default:      read_mux = '0;
    endcase
  end

  // Registered read data, one clock of latency, no read side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= read_mux;
  end

endmodule

// File: tb/tb_lab62_soc_irq_ctrl.sv
// tb_lab62_soc_irq_ctrl: directed, table-driven bench for the irq aggregator.
module tb_lab62_soc_irq_ctrl;

  localparam logic [2:0] A_RAW     = 3'd0;
  localparam logic [2:0] A_PENDING = 3'd1;
  localparam logic [2:0] A_ENABLE  = 3'd2;
  localparam logic [2:0] A_MODE    = 3'd3;
  localparam logic [2:0] A_ACTIVE  = 3'd4;
  localparam logic [2:0] A_COUNT   = 3'd5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  irq;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [13];

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  lab62_soc_irq_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_out    (irq_out)
  );

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, want 0x%04h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic apply_stimulus(input int idx);
    logic [15:0] rd;
    irq_in = vecs[idx].irq;
    step(4);
    write_reg(vecs[idx].waddr, vecs[idx].wdata);
    read_reg(vecs[idx].raddr, rd);
    check_output($sformatf("vec%0d_read", idx), rd, vecs[idx].exp_rd);
    check_output($sformatf("vec%0d_irq", idx), {15'b0, irq_out}, {15'b0, vecs[idx].exp_irq});
  endtask

  // One edge event on source 0 (edge mode, enabled), then acknowledge it.
  task automatic edge_event();
    irq_in = 8'h01;
    step(1);
    irq_in = 8'h00;
    step(5);
    write_reg(A_PENDING, 16'h0001);
    step(3);
  endtask

  initial begin
    logic [15:0] rd;

    vecs[0]  = '{8'h0A, A_ENABLE,  16'h00FF, A_ACTIVE,  16'h8001, 1'b1};
    vecs[1]  = '{8'h0A, A_ENABLE,  16'h0008, A_ACTIVE,  16'h8003, 1'b1};
    vecs[2]  = '{8'h0A, A_ENABLE,  16'h0000, A_ACTIVE,  16'h0000, 1'b0};
    vecs[3]  = '{8'h0A, 3'd7,      16'hFFFF, A_RAW,     16'h000A, 1'b0};
    vecs[4]  = '{8'h0A, A_ENABLE,  16'hFFFF, A_ENABLE,  16'h00FF, 1'b1};
    vecs[5]  = '{8'h0A, A_MODE,    16'h00F0, A_MODE,    16'h00F0, 1'b1};
    vecs[6]  = '{8'h0A, 3'd6,      16'h1234, 3'd6,      16'h0000, 1'b1};
    vecs[7]  = '{8'h0A, A_PENDING, 16'hFFFF, A_PENDING, 16'h000A, 1'b1};
    vecs[8]  = '{8'h80, A_MODE,    16'h0000, A_ACTIVE,  16'h8007, 1'b1};
    vecs[9]  = '{8'h00, A_ENABLE,  16'h0000, A_PENDING, 16'h0000, 1'b0};
    vecs[10] = '{8'h05, A_ENABLE,  16'h0006, A_ACTIVE,  16'h8002, 1'b1};
    vecs[11] = '{8'h05, A_MODE,    16'h0004, A_PENDING, 16'h0001, 1'b0};
    vecs[12] = '{8'h00, A_MODE,    16'h0000, A_PENDING, 16'h0000, 1'b0};

    reset_n    = 1'b0;
    irq_in     = 8'h00;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;

    // Reset values.
    #1;
    check_output("reset_irq", {15'b0, irq_out}, 16'h0000);
    check_output("reset_readdata", readdata, 16'h0000);
    step(2);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), rd);
      check_output($sformatf("reset_read_a%0d", a), rd, 16'h0000);
      check_output($sformatf("reset_irq_a%0d", a), {15'b0, irq_out}, 16'h0000);
    end

    // Table: priority, masking, unused addresses, register widths.
    for (int i = 0; i < 13; i++) apply_stimulus(i);

    // Edge capture and W1C.
    write_reg(A_MODE, 16'h0001);
    write_reg(A_ENABLE, 16'h0001);
    step(4);
    irq_in = 8'h01;
    step(1);
    irq_in = 8'h00;
    step(2);
    check_output("edge_irq_e2", {15'b0, irq_out}, 16'h0000);
    step(1);
    check_output("edge_irq_e3", {15'b0, irq_out}, 16'h0001);
    read_reg(A_PENDING, rd);
    check_output("edge_pending", rd, 16'h0001);
    read_reg(A_ACTIVE, rd);
    check_output("edge_active", rd, 16'h8000);
    write_reg(A_PENDING, 16'h0001);
    check_output("w1c_irq_hold", {15'b0, irq_out}, 16'h0001);
    step(1);
    check_output("w1c_irq_fall", {15'b0, irq_out}, 16'h0000);
    read_reg(A_PENDING, rd);
    check_output("w1c_pending", rd, 16'h0000);

    // Level follow.
    write_reg(A_MODE, 16'h0000);
    write_reg(A_ENABLE, 16'h0004);
    step(2);
    irq_in = 8'h04;
    step(2);
    check_output("level_irq_e1", {15'b0, irq_out}, 16'h0000);
    step(1);
    check_output("level_irq_e2", {15'b0, irq_out}, 16'h0001);
    write_reg(A_PENDING, 16'h0004);
    step(2);
    check_output("level_w1c_ignored", {15'b0, irq_out}, 16'h0001);
    irq_in = 8'h00;
    step(2);
    check_output("level_fall_e1", {15'b0, irq_out}, 16'h0001);
    step(1);
    check_output("level_fall_e2", {15'b0, irq_out}, 16'h0000);

    // Set/clear collision on edge bit 1.
    write_reg(A_ENABLE, 16'h0002);
    write_reg(A_MODE, 16'h0002);
    irq_in = 8'h02;
    step(4);
    check_output("coll_irq_set", {15'b0, irq_out}, 16'h0001);
    irq_in = 8'h00;
    step(4);
    irq_in = 8'h02;
    step(2);
    write_reg(A_PENDING, 16'h0002);
    check_output("coll_irq_a", {15'b0, irq_out}, 16'h0001);
    step(1);
    check_output("coll_irq_b", {15'b0, irq_out}, 16'h0001);
    read_reg(A_PENDING, rd);
    check_output("coll_pending", rd, 16'h0002);
    write_reg(A_PENDING, 16'h0002);
    step(1);
    check_output("coll_clear_irq", {15'b0, irq_out}, 16'h0000);
    read_reg(A_PENDING, rd);
    check_output("coll_clear_pending", rd, 16'h0000);
    irq_in = 8'h00;

    // COUNT: three edge events.
    write_reg(A_MODE, 16'h0001);
    write_reg(A_ENABLE, 16'h0001);
    step(4);
    write_reg(A_COUNT, 16'hABCD);
    for (int n = 0; n < 3; n++) edge_event();
    read_reg(A_COUNT, rd);
    check_output("count_three", rd, 16'h0003);

    // COUNT saturation, preloaded near the top to stay within a short run.
    force dut.count_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.count_q;
    @(negedge clk);
    read_reg(A_COUNT, rd);
    check_output("count_preload", rd, 16'hFFFD);
    edge_event();
    read_reg(A_COUNT, rd);
    check_output("count_fffe", rd, 16'hFFFE);
    edge_event();
    read_reg(A_COUNT, rd);
    check_output("count_ffff", rd, 16'hFFFF);
    edge_event();
    read_reg(A_COUNT, rd);
    check_output("count_saturate", rd, 16'hFFFF);

    // COUNT clear colliding with an irq_out rise.
    write_reg(A_ENABLE, 16'h0000);
    write_reg(A_MODE, 16'h0000);
    irq_in = 8'h01;
    step(4);
    write_reg(A_ENABLE, 16'h0001);
    step(1);
    check_output("count_coll_irq", {15'b0, irq_out}, 16'h0001);
    write_reg(A_COUNT, 16'h5555);
    read_reg(A_COUNT, rd);
    check_output("count_clear_wins", rd, 16'h0000);

    // Asynchronous reset mid-operation.
    read_reg(A_ENABLE, rd);
    check_output("pre_reset_enable", rd, 16'h0001);
    #3;
    reset_n = 1'b0;
    #1;
    check_output("midreset_irq", {15'b0, irq_out}, 16'h0000);
    check_output("midreset_readdata", readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(A_ENABLE, rd);
    check_output("postreset_enable", rd, 16'h0000);
    read_reg(A_COUNT, rd);
    check_output("postreset_count", rd, 16'h0000);
    check_output("postreset_irq", {15'b0, irq_out}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
